// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage register: occupancy states and per-stage payloads.
// Build with PIPE_SKID_EN defined to enable the two-entry skid variant of pipe_stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipeOcc_t;

  // ID/EX payload; control fields must be zero in the bubble so a squashed slot is harmless.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [31:0] imm;
    logic [3:0]  aluOp;
    logic [2:0]  memOp;
    logic [4:0]  rd;
    logic        regWrite;
  } idex_t;

  localparam int IDEX_W = $bits(idex_t);
  localparam idex_t IDEX_BUBBLE = '0;

  typedef struct packed {
    logic [31:0] aluRes;
    logic [31:0] storeVal;
    logic [2:0]  memOp;
    logic [4:0]  rd;
    logic        regWrite;
  } exmem_t;

  localparam int EXMEM_W = $bits(exmem_t);
  localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with a valid bit; clear and drain both return the data to RST_VAL.
module pipe_slot #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // Data is reset too, so an empty slot always presents the bubble value.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= 1'b0;
      q     <= RST_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
      q     <= RST_VAL;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Generic pipeline stage register with valid/ready handshake, flush and bubble value.
// Define PIPE_SKID_EN for a skid slot that makes in_ready a register output.
import pipe_pkg::*;

module pipe_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipeOcc_t         state;
  pipeOcc_t         stateNext;
  logic             clear;
  logic             inXfer;
  logic             outXfer;
  logic             mainLoad;
  logic             mainDrop;
  logic             mainValid;
  logic [WIDTH-1:0] mainD;
  logic [WIDTH-1:0] mainQ;

  assign clear = reset | flush;

`ifdef PIPE_SKID_EN
  logic             skidLoad;
  logic             skidDrop;
  logic             skidValid;
  logic [WIDTH-1:0] skidQ;

  assign in_ready = flush | ~skidValid;
`else
  assign in_ready = flush | out_ready | ~mainValid;
`endif

  // A payload offered during flush is discarded even though in_ready reads 1.
  assign inXfer  = in_valid & in_ready & ~flush;
  assign outXfer = mainValid & out_ready;

  always_comb begin
    stateNext = state;
    mainLoad  = 1'b0;
    mainDrop  = 1'b0;
    mainD     = in_data;
`ifdef PIPE_SKID_EN
    skidLoad  = 1'b0;
    skidDrop  = 1'b0;
`endif
    case (state)
      PIPE_EMPTY: begin
        if (inXfer) begin
          mainLoad  = 1'b1;
          stateNext = PIPE_ONE;
        end
      end
      PIPE_ONE: begin
        if (inXfer && outXfer) begin
          mainLoad = 1'b1;
        end else if (outXfer) begin
          mainDrop  = 1'b1;
          stateNext = PIPE_EMPTY;
`ifdef PIPE_SKID_EN
        end else if (inXfer) begin
          skidLoad  = 1'b1;
          stateNext = PIPE_FULL;
`endif
        end
      end
`ifdef PIPE_SKID_EN
      PIPE_FULL: begin
        if (outXfer) begin
          mainLoad  = 1'b1;
          mainD     = skidQ;
          skidDrop  = 1'b1;
          stateNext = PIPE_ONE;
        end
      end
`endif
      default: stateNext = PIPE_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) state <= PIPE_EMPTY;
    else       state <= stateNext;
  end

  pipe_slot #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) mainSlot (
    .clk   (clk),
    .clear (clear),
    .load  (mainLoad),
    .drop  (mainDrop),
    .d     (mainD),
    .valid (mainValid),
    .q     (mainQ)
  );

`ifdef PIPE_SKID_EN
  pipe_slot #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) skidSlot (
    .clk   (clk),
    .clear (clear),
    .load  (skidLoad),
    .drop  (skidDrop),
    .d     (in_data),
    .valid (skidValid),
    .q     (skidQ)
  );
`endif

  assign out_valid = mainValid;
  assign out_data  = mainQ;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage.sv
// Randomised and directed bench for pipe_stage against a queue model of the stage.
// Honours PIPE_SKID_EN to select the two-entry or single-entry expectations.
module tb_pipe_stage;

  localparam int W = 32;
  localparam logic [W-1:0] RSTV = '0;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  int nCmp = 0;
  int nBad = 0;
  logic [W-1:0] q[$];

  pipe_stage #(.WIDTH(W), .RST_VAL(RSTV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic modelInReady(logic fl, logic ordy);
`ifdef PIPE_SKID_EN
    return fl || (q.size() < CAP);
`else
    return fl || ordy || (q.size() == 0);
`endif
  endfunction

  task automatic cmp(string name, logic [W-1:0] act, logic [W-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    cmp("model.out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    cmp("model.out_data", out_data, (q.size() != 0) ? q[0] : RSTV);
    cmp("model.occupancy", {30'd0, occupancy}, W'(q.size()));
    cmp("model.in_ready", {31'd0, in_ready}, {31'd0, modelInReady(flush, out_ready)});
  endtask

  // Drive one cycle of inputs, check before the edge, then advance the model across it.
  task automatic cyc(logic rst, logic fl, logic iv, logic [W-1:0] id, logic ordy, logic chk);
    logic ir;
    reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    if (chk) compareModel();
    ir = modelInReady(fl, ordy);
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (fl) q.delete();
      else if (iv && ir) q.push_back(id);
    end
    #1;
  endtask

  task automatic lit(string name, logic [W-1:0] act, logic [W-1:0] exp);
    cmp(name, act, exp);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, '0, 0, 1);
    cyc(0, 0, 0, '0, 0, 1);
    lit("reset.out_valid", {31'd0, out_valid}, 32'd0);
    lit("reset.out_data", out_data, 32'd0);
    lit("reset.occupancy", {30'd0, occupancy}, 32'd0);
    lit("reset.in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream
    cyc(0, 0, 1, 32'h11, 1, 1);
    lit("stream.d0", out_data, 32'h11);
    lit("stream.occ0", {30'd0, occupancy}, 32'd1);
    cyc(0, 0, 1, 32'h22, 1, 1);
    lit("stream.d1", out_data, 32'h22);
    lit("stream.occ1", {30'd0, occupancy}, 32'd1);
    cyc(0, 0, 1, 32'h33, 1, 1);
    lit("stream.d2", out_data, 32'h33);
    lit("stream.occ2", {30'd0, occupancy}, 32'd1);
    cyc(0, 0, 0, '0, 1, 1);
    lit("stream.drain", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_EN
    cyc(0, 0, 1, 32'hA, 0, 1);
    cyc(0, 0, 1, 32'hB, 0, 1);
    lit("skid.occ", {30'd0, occupancy}, 32'd2);
    lit("skid.in_ready", {31'd0, in_ready}, 32'd0);
    lit("skid.head", out_data, 32'hA);
    cyc(0, 0, 0, '0, 1, 1);
    lit("skid.pop1", out_data, 32'hB);
    lit("skid.ready_back", {31'd0, in_ready}, 32'd1);
    cyc(0, 0, 0, '0, 1, 1);
    lit("skid.empty", {31'd0, out_valid}, 32'd0);
    cyc(0, 0, 1, 32'hA, 0, 1);
    cyc(0, 0, 1, 32'hB, 0, 1);
    cyc(0, 1, 1, 32'hC, 0, 1);
    lit("flush.occ", {30'd0, occupancy}, 32'd0);
    lit("flush.out_valid", {31'd0, out_valid}, 32'd0);
    lit("flush.out_data", out_data, RSTV);
    cyc(0, 0, 0, '0, 1, 1);
    lit("flush.no_c", {31'd0, out_valid}, 32'd0);
`else
    cyc(0, 0, 1, 32'h55, 0, 1);
    cyc(0, 0, 1, 32'h66, 0, 1);
    lit("stall.hold", out_data, 32'h55);
    lit("stall.in_ready", {31'd0, in_ready}, 32'd0);
    lit("stall.occ", {30'd0, occupancy}, 32'd1);
    cyc(0, 1, 1, 32'hC, 0, 1);
    lit("flush.occ", {30'd0, occupancy}, 32'd0);
    lit("flush.out_data", out_data, RSTV);
`endif

    // Reset wins over flush; offered payload is dropped
    cyc(0, 0, 1, 32'h77, 0, 1);
    cyc(1, 1, 1, 32'h99, 1, 1);
    lit("rstflush.occ", {30'd0, occupancy}, 32'd0);
    lit("rstflush.out_valid", {31'd0, out_valid}, 32'd0);
    cyc(0, 0, 0, '0, 0, 1);
    lit("rstflush.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 5), 1);
      if (occupancy > 2'(CAP)) lit("occ.bound", {30'd0, occupancy}, CAP);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
